// File: rtl/md_unit.sv
// Purpose : multiply/divide unit with architectural HI/LO registers (mult, multu, div, divu, mthi, mtlo).
// Latency : mult/multu MULT_CYCLES, div/divu DIV_CYCLES; mthi/mtlo write HI/LO at the accepting edge.
// Backpr. : Busy high while an operation is in flight; start is ignored then, except at the completing edge.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   D1          operand A (rs / dividend / mthi-mtlo data)
//   D2          operand B (rt / divisor)
//   mult_div_op 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved
//   start       one-cycle request strobe
//   Busy        registered, high while an operation is in flight
//   HI, LO      result registers
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   input  logic [2:0]  mult_div_op,
   input  logic        start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   state_e             state_q, state_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;     // only the long ops are latched
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;

   // ---------------------------------------------------------------
   // Result datapath, evaluated from the latched operands only.
   // ---------------------------------------------------------------
   logic [63:0] prod_s, prod_u;
   logic        b_zero;
   logic [31:0] b_safe;
   logic [31:0] uq, ur;
   logic [31:0] abs_a, abs_b;
   logic [31:0] mag_q, mag_r;
   logic [31:0] sq, sr;

   // Sign-extending to 64 bits makes the low 64 bits of an unsigned
   // multiply equal to the signed product.
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // A zero divisor never writes a result; substitute 1 so the
   // divider never sees a zero operand.
   assign b_zero = (b_q == 32'd0);
   assign b_safe = b_zero ? 32'd1 : b_q;

   assign uq = a_q / b_safe;
   assign ur = a_q % b_safe;

   // Signed divide on magnitudes. 0x80000000 / -1 falls out naturally:
   // magnitude quotient 0x80000000, not negated, remainder 0.
   assign abs_a = a_q[31]    ? (32'd0 - a_q)    : a_q;
   assign abs_b = b_safe[31] ? (32'd0 - b_safe) : b_safe;
   assign mag_q = abs_a / abs_b;
   assign mag_r = abs_a % abs_b;
   assign sq    = (a_q[31] ^ b_safe[31]) ? (32'd0 - mag_q) : mag_q;
   assign sr    = a_q[31] ? (32'd0 - mag_r) : mag_r;

   // ---------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------
   logic done;
   logic can_accept;

   assign done       = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));
   // The completing edge doubles as an idle edge so operations can
   // run back to back.
   assign can_accept = (state_q == S_IDLE) || done;

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      if (state_q == S_BUSY) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (done) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            case (op_q)
               2'b00: begin
                  hi_d = prod_s[63:32];
                  lo_d = prod_s[31:0];
               end
               2'b01: begin
                  hi_d = prod_u[63:32];
                  lo_d = prod_u[31:0];
               end
               2'b10: begin
                  if (!b_zero) begin
                     hi_d = sr;
                     lo_d = sq;
                  end
               end
               default: begin
                  if (!b_zero) begin
                     hi_d = ur;
                     lo_d = uq;
                  end
               end
            endcase
         end
      end

      // A new request applied on the completing edge is later in
      // program order, so an mthi/mtlo there overrides the result half.
      if (can_accept && start) begin
         case (mult_div_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
               state_d = S_BUSY;
               busy_d  = 1'b1;
               op_d    = mult_div_op[1:0];
               a_d     = D1;
               b_d     = D2;
               cnt_d   = mult_div_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
            OP_MTHI: hi_d = D1;
            OP_MTLO: lo_d = D1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Purpose : directed self-checking bench for md_unit.
// Latency : inputs driven just after the falling edge, outputs sampled on the falling edge.
// Backpr. : Busy is polled with a bounded cycle budget; an expired budget shows up as a wrong cycle count.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic [31:0] D1;
   logic [31:0] D2;
   logic [2:0]  mult_div_op;
   logic        start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   md_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .D1          (D1),
      .D2          (D2),
      .mult_div_op (mult_div_op),
      .start       (start),
      .Busy        (Busy),
      .HI          (HI),
      .LO          (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start       = 1'b1;
      mult_div_op = op;
      D1          = a;
      D2          = b;
      @(negedge clk);
      start       = 1'b0;
   endtask

   // Counts Busy-high samples (bounded), checks HI/LO hold mid-operation,
   // scrambles operands, and optionally fires an mthi while busy.
   task automatic wait_busy(input string tag, input int n,
                            input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                            input bit inject_mthi);
      int cnt;
      cnt = 0;
      while (Busy && cnt < 50) begin
         cnt++;
         if (cnt == 2) begin
            chk({tag, "_hold_hi"}, HI, hold_hi);
            chk({tag, "_hold_lo"}, LO, hold_lo);
            D1 = $urandom;
            D2 = $urandom;
         end
         if (inject_mthi && cnt == 3) begin
            start       = 1'b1;
            mult_div_op = 3'b100;
            D1          = 32'hABCD0000;
         end
         if (inject_mthi && cnt == 4) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      D1          = 32'd0;
      D2          = 32'd0;
      mult_div_op = 3'b000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // mult -2 * 3 with an mthi fired mid-operation (must be ignored)
      go(3'b000, 32'hFFFFFFFE, 32'd3);
      chk("mult_busy_t0", 32'(Busy), 32'd1);
      wait_busy("mult", 5, 32'd0, 32'd0, 1'b1);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFFA);

      // mthi while idle: immediate, no Busy
      go(3'b100, 32'hABCD0000, 32'd0);
      chk("mthi_hi", HI, 32'hABCD0000);
      chk("mthi_busy", 32'(Busy), 32'd0);
      chk("mthi_lo", LO, 32'hFFFFFFFA);

      // multu same operands
      go(3'b001, 32'hFFFFFFFE, 32'd3);
      wait_busy("multu", 5, 32'hABCD0000, 32'hFFFFFFFA, 1'b0);
      chk("multu_hi", HI, 32'h00000002);
      chk("multu_lo", LO, 32'hFFFFFFFA);

      // div -7 / 2
      go(3'b010, 32'hFFFFFFF9, 32'd2);
      wait_busy("div", 10, 32'h00000002, 32'hFFFFFFFA, 1'b0);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);

      // div 7 / -2 -> q=-3, r=1
      go(3'b010, 32'd7, 32'hFFFFFFFE);
      wait_busy("div2", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      chk("div2_lo", LO, 32'hFFFFFFFD);
      chk("div2_hi", HI, 32'h00000001);

      // div overflow case
      go(3'b010, 32'h80000000, 32'hFFFFFFFF);
      wait_busy("divov", 10, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      chk("divov_lo", LO, 32'h80000000);
      chk("divov_hi", HI, 32'h00000000);

      // divu 0xFFFFFFFF / 16
      go(3'b011, 32'hFFFFFFFF, 32'd16);
      wait_busy("divu", 10, 32'h00000000, 32'h80000000, 1'b0);
      chk("divu_lo", LO, 32'h0FFFFFFF);
      chk("divu_hi", HI, 32'h0000000F);

      // divu by zero with preloaded HI/LO
      go(3'b100, 32'h11111111, 32'd0);
      go(3'b101, 32'h22222222, 32'd0);
      chk("pre_hi", HI, 32'h11111111);
      chk("pre_lo", LO, 32'h22222222);
      go(3'b011, 32'd7, 32'd0);
      wait_busy("divz", 10, 32'h11111111, 32'h22222222, 1'b0);
      chk("divz_hi", HI, 32'h11111111);
      chk("divz_lo", LO, 32'h22222222);

      // reserved op ignored
      go(3'b110, 32'hDEADBEEF, 32'd1);
      chk("rsv_busy", 32'(Busy), 32'd0);
      chk("rsv_hi", HI, 32'h11111111);
      chk("rsv_lo", LO, 32'h22222222);

      // back-to-back: multu accepted on the completing edge of mult 3*4
      go(3'b000, 32'd3, 32'd4);
      repeat (4) @(negedge clk);
      chk("b2b_busy_pre", 32'(Busy), 32'd1);
      go(3'b001, 32'd5, 32'd6);
      chk("b2b_busy_t0", 32'(Busy), 32'd1);
      chk("b2b_first_lo", LO, 32'd12);
      chk("b2b_first_hi", HI, 32'd0);
      wait_busy("b2b", 5, 32'd0, 32'd12, 1'b0);
      chk("b2b_lo", LO, 32'd30);
      chk("b2b_hi", HI, 32'd0);

      // reset at cycle 3 of a div, with a simultaneous mthi that must lose
      go(3'b100, 32'h00000055, 32'd0);
      go(3'b010, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      reset       = 1'b1;
      start       = 1'b1;
      mult_div_op = 3'b100;
      D1          = 32'h00000077;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      chk("rdiv_busy", 32'(Busy), 32'd0);
      chk("rdiv_hi", HI, 32'd0);
      chk("rdiv_lo", LO, 32'd0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("rdiv_idle_busy", 32'(Busy), 32'd0);
         chk("rdiv_idle_hi", HI, 32'd0);
         chk("rdiv_idle_lo", LO, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameters SHALL be:
- MULT_CYCLES, default 5, Busy cycles for mult/multu.
- DIV_CYCLES, default 10, Busy cycles for div/divu.

REQ-002 Ports SHALL be, in this order:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- D1  input  32  operand A (rs, dividend); forwarded value from the Execute stage.
- D2  input  32  operand B (rt, divisor).
- mult_div_op  input  3  operation code.
- start  input  1  one-cycle request strobe from the Execute stage.
- Busy  output  1  high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

REQ-003 Operation codes SHALL be:
- 000 mult
- 001 multu
- 010 div
- 011 divu
- 100 mthi
- 101 mtlo
- 110 and 111 reserved.

Function
REQ-004 The block SHALL be a two-state FSM: IDLE and BUSY.
REQ-005 Busy SHALL be a registered output: 0 in IDLE, 1 in BUSY.
REQ-006 In IDLE, start=1 with op 000-011 at edge t0 SHALL:
- latch D1, D2 and the op;
- load the cycle counter with MULT_CYCLES or DIV_CYCLES as appropriate;
- enter BUSY.
REQ-007 Busy SHALL be high for exactly N cycles after t0, where N is the latency from REQ-006.
REQ-008 At edge t0+N, Busy SHALL return to 0 and HI/LO SHALL update.
REQ-009 The next start SHALL be accepted at edge t0+N itself (back-to-back operations).
REQ-010 During BUSY, HI and LO SHALL hold their pre-operation values.
REQ-011 mult SHALL form the signed 64-bit product of D1 and D2: {HI,LO} = product.
REQ-012 multu SHALL form the unsigned 64-bit product of D1 and D2: {HI,LO} = product.
REQ-013 div SHALL compute signed LO=quotient, HI=remainder.
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-014 divu SHALL compute unsigned LO=quotient, HI=remainder.
REQ-015 div with D1=0x80000000 and D2=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-016 div/divu with a latched divisor of 0 SHALL still run the full DIV_CYCLES with Busy high; HI and LO SHALL stay unchanged at completion.
REQ-017 In IDLE, start=1 with op 100 SHALL write D1 into HI at that edge.
REQ-018 In IDLE, start=1 with op 101 SHALL write D1 into LO at that edge.
REQ-019 mthi and mtlo SHALL not assert Busy and SHALL have zero added latency.
REQ-020 start=1 with op 110/111 SHALL be ignored: no state change.
REQ-021 start asserted during BUSY SHALL be ignored for every op, including mthi/mtlo.
REQ-022 Operands SHALL be sampled only at the accepting edge; changes to D1/D2 during BUSY SHALL not affect the result.
REQ-023 Result width rules:
- Multiply uses the full 64-bit product.
- Divide results are 32 bits each.
- No overflow or exception flags exist.
REQ-024 HI and LO SHALL be driven directly from registers, with no combinational path from D1/D2/start.

Reset
REQ-025 reset=1 at a rising edge SHALL force:
- state to IDLE;
- Busy to 0;
- HI to 0x00000000 and LO to 0x00000000;
- cycle counter to 0.
REQ-026 reset SHALL take priority over start in the same cycle.
REQ-027 reset during BUSY SHALL abort the operation; no result SHALL be written afterwards.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- mult: D1=0xFFFFFFFE (-2), D2=3, one-cycle start -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: same operands -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA.
- div: D1=-7, D2=2 -> Busy=1 for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: D1=7, D2=0, with HI/LO preloaded to 0x11111111/0x22222222 -> Busy=1 for 10 cycles; HI/LO unchanged.
- mthi during BUSY: D1=0xABCD0000 asserted mid-mult -> ignored. After Busy falls, mthi with 0xABCD0000 -> HI=0xABCD0000 on the next edge, Busy stays 0.
- reset at cycle 3 of a div -> Busy=0 and HI=LO=0 on the next edge; outputs stay 0 for 15 further idle cycles.
